debug_dump_serializer: RTL and testbench
========================================

Name: debug_dump_serializer

Overview:
- Parametrised debug snapshot serializer for the MIPS debug path.
- On a start request it latches N_WORDS words of WORD_W bits each, from one flat bus, in a single cycle.
- It then streams the snapshot byte-wise into the UART TX FIFO as a framed dump: optional sync byte, payload, optional XOR checksum.
- The frame is paced by the FIFO full flag, and the block reports busy/done to the debug controller.

Parameters:
- N_WORDS, 127, number of words captured per snapshot (>=1).
- WORD_W, 32, bits per word (1..64). BPW = ceil(WORD_W/8) bytes per word; each word is zero-extended to BPW*8 bits.
- MSB_FIRST, 1, 1 = most significant byte of each word sent first; 0 = least significant byte first.
- HEADER_EN, 1, 1 = prepend SYNC_BYTE to each frame.
- SYNC_BYTE, 8'hA5, frame sync value.
- CHECKSUM_EN, 1, 1 = append the XOR of all payload bytes (header excluded).

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous, active-high reset
- I_START  in  1  dump request; sampled only in IDLE
- I_DATA  in  N_WORDS*WORD_W  snapshot bus; word k = I_DATA[k*WORD_W +: WORD_W]
- I_TX_FULL  in  1  UART TX FIFO full
- O_WR_UART  out  1  FIFO write strobe; one byte per asserted cycle
- O_DATA_UART  out  8  byte presented with O_WR_UART
- O_BUSY  out  1  high whenever state != IDLE
- O_DONE  out  1  one-cycle pulse after the final byte is written

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - state = IDLE; word/byte counters = 0; checksum accumulator = 0; snapshot registers = 0.
  - O_WR_UART = 0, O_DATA_UART = 0, O_BUSY = 0, O_DONE = 0.
  - An aborted frame is not resumed.
- States: IDLE, HDR, SEND, CHK, DONE.
- IDLE:
  - On an edge with I_START = 1: latch all of I_DATA into the snapshot registers, clear the counters and the checksum, go to HDR (HEADER_EN = 1) or SEND (HEADER_EN = 0).
  - I_DATA changes after this capture edge do not affect the frame.
- Emitting states (HDR, SEND, CHK):
  - O_WR_UART = ~I_TX_FULL, combinational.
  - O_DATA_UART is a combinational mux of registered state/counters: SYNC_BYTE in HDR, the current payload byte in SEND, the checksum in CHK.
  - A byte counts as sent only on a clock edge where O_WR_UART = 1.
  - While I_TX_FULL = 1: hold state, counters and O_DATA_UART; no byte is lost or duplicated.
- Transitions:
  - HDR: after its byte is sent -> SEND.
  - SEND: byte index b runs 0..BPW-1 inside word index w, which runs 0..N_WORDS-1. The byte sent for (w,b) is byte (BPW-1-b) of word w when MSB_FIRST = 1, byte b otherwise. Each sent byte is XORed into the checksum.
  - SEND: after the byte (N_WORDS-1, BPW-1) is sent -> CHK (CHECKSUM_EN = 1) or DONE (CHECKSUM_EN = 0).
  - CHK: after its byte is sent -> DONE.
  - DONE: O_WR_UART = 0, O_DONE = 1 for exactly this cycle, then -> IDLE.
- Throughput and latency:
  - Maximum rate is one byte per clock.
  - With I_TX_FULL = 0 throughout, the first write strobe occurs in the cycle immediately after the capture edge.
  - Frame length = HEADER_EN + N_WORDS*BPW + CHECKSUM_EN bytes, written on consecutive cycles.
  - O_DONE occurs one cycle after the last write.
- Start handling:
  - I_START while O_BUSY = 1 is ignored; it is not queued.
  - I_START held high across DONE->IDLE starts a new frame on the first IDLE edge, i.e. back-to-back frames with one idle cycle between them.
- Counter widths: w is clog2(N_WORDS) bits (min 1); b is clog2(BPW) bits (min 1).
- Outside the emitting states, O_WR_UART = 0 and O_DATA_UART = 0.

Test Plan:
- N_WORDS=2, WORD_W=32, defaults, words 0x11223344 and 0xAABBCCDD, I_TX_FULL=0, pulse I_START -> 10 consecutive writes: A5 11 22 33 44 AA BB CC DD 44. O_DONE pulses one cycle after the final 0x44; O_BUSY is high from the capture edge until IDLE.
- Same data with MSB_FIRST=0 -> A5 44 33 22 11 DD CC BB AA 44.
- Same data; hold I_TX_FULL=1 for 5 cycles while the third byte (0x22) is pending -> O_WR_UART stays low and O_DATA_UART stays 0x22 throughout; the resumed stream is identical and still 10 bytes total.
- WORD_W=12, N_WORDS=1, HEADER_EN=0, CHECKSUM_EN=0, word 0xABC -> writes 0x0A 0xBC, then O_DONE. Changing I_DATA after the capture edge does not alter the bytes.
- Assert RESET after the 4th byte of the 2-word frame -> all outputs 0 immediately. The next I_START produces a complete 10-byte frame starting with A5.
- Pulse I_START mid-frame -> ignored, only one frame emitted. Hold I_START high continuously -> two back-to-back frames separated by exactly one idle cycle.

Source files
------------

// File: rtl/debug_dump_serializer.sv
// debug_dump_serializer: latches a word snapshot in one cycle and streams it
// byte-wise into the UART TX FIFO as a sync/payload/XOR-checksum frame.
module debug_dump_serializer #(
  parameter int         N_WORDS     = 127,
  parameter int         WORD_W      = 32,
  parameter bit         MSB_FIRST   = 1'b1,
  parameter bit         HEADER_EN   = 1'b1,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter bit         CHECKSUM_EN = 1'b1
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      I_START,
  input  logic [N_WORDS*WORD_W-1:0] I_DATA,
  input  logic                      I_TX_FULL,
  output logic                      O_WR_UART,
  output logic [7:0]                O_DATA_UART,
  output logic                      O_BUSY,
  output logic                      O_DONE
);

  localparam int BPW = (WORD_W + 7) / 8;
  localparam int WB  = BPW * 8;
  localparam int WCW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [WCW-1:0] W_LAST = WCW'(N_WORDS - 1);
  localparam logic [BCW-1:0] B_LAST = BCW'(BPW - 1);

  typedef enum logic [2:0] {
    IDLE, HDR, SEND, CHK, DONE
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [WB-1:0]  snap_q [N_WORDS];
  logic [WCW-1:0] w_q;
  logic [BCW-1:0] b_q;
  logic [7:0]     chk_q;
  logic [WB-1:0]  cur_word;
  logic [BCW-1:0] sel_b;
  logic [7:0]     cur_byte;
  logic           last;
  logic           capture;
  logic           sent;

  // Mux loops instead of variable indexing keep N_WORDS=1 / BPW=1 clean.
  always_comb begin
    cur_word = '0;
    for (int k = 0; k < N_WORDS; k++) begin
      if (w_q == WCW'(k)) cur_word = snap_q[k];
    end
  end

  assign sel_b = MSB_FIRST ? (B_LAST - b_q) : b_q;

  always_comb begin
    cur_byte = '0;
    for (int j = 0; j < BPW; j++) begin
      if (sel_b == BCW'(j)) cur_byte = cur_word[j*8 +: 8];
    end
  end

  assign last    = (w_q == W_LAST) && (b_q == B_LAST);
  assign capture = (state_q == IDLE) && I_START;
  assign sent    = (state_q == SEND) && !I_TX_FULL;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    O_WR_UART   = 1'b0;
    O_DATA_UART = 8'h00;
    O_BUSY      = (state_q != IDLE);
    O_DONE      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (I_START) state_d = HEADER_EN ? HDR : SEND;
      end
      HDR: begin
        O_WR_UART   = ~I_TX_FULL;
        O_DATA_UART = SYNC_BYTE;
        if (!I_TX_FULL) state_d = SEND;
      end
      SEND: begin
        O_WR_UART   = ~I_TX_FULL;
        O_DATA_UART = cur_byte;
        if (!I_TX_FULL && last) begin
          state_d = CHECKSUM_EN ? CHK : DONE;
        end
      end
      CHK: begin
        O_WR_UART   = ~I_TX_FULL;
        O_DATA_UART = chk_q;
        if (!I_TX_FULL) state_d = DONE;
      end
      DONE: begin
        O_DONE  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      w_q   <= '0;
      b_q   <= '0;
      chk_q <= '0;
      for (int k = 0; k < N_WORDS; k++) snap_q[k] <= '0;
    end else if (capture) begin
      w_q   <= '0;
      b_q   <= '0;
      chk_q <= '0;
      for (int k = 0; k < N_WORDS; k++) begin
        snap_q[k] <= WB'(I_DATA[k*WORD_W +: WORD_W]);
      end
    end else if (sent) begin
      chk_q <= chk_q ^ cur_byte;
      if (b_q == B_LAST) begin
        b_q <= '0;
        w_q <= w_q + 1'b1;
      end else begin
        b_q <= b_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_debug_dump_serializer.sv
// tb_debug_dump_serializer: four differently configured serializers,
// frames checked against a byte-list model of the dump format.
module tb_debug_dump_serializer;

  logic        CLK       = 1'b0;
  logic        RESET     = 1'b1;
  logic        I_START   = 1'b0;
  logic        I_TX_FULL = 1'b0;
  logic [63:0] data_a    = '0;
  logic [63:0] data_b    = '0;
  logic [11:0] data_c    = '0;
  logic [59:0] data_d    = '0;
  logic        wr   [4];
  logic [7:0]  dat  [4];
  logic        busy [4];
  logic        done [4];
  int          msel = 0;
  logic        mwr, mbusy, mdone;
  logic [7:0]  mdat;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  got[$];
  logic [7:0]  exp[$];
  logic [7:0]  stall_d[$];
  int          t_wr[$];
  int          t_done[$];
  int          idle_n, extra, full_wr, c0;

  int         cn [4] = '{2, 2, 1, 3};
  int         cw [4] = '{32, 32, 12, 20};
  bit         cm [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  bit         ch [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  bit         cc [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  logic [7:0] cs [4] = '{8'hA5, 8'hA5, 8'hA5, 8'h3C};

  debug_dump_serializer #(.N_WORDS(2), .WORD_W(32)) dut_a (
    .CLK(CLK), .RESET(RESET), .I_START(I_START), .I_DATA(data_a),
    .I_TX_FULL(I_TX_FULL), .O_WR_UART(wr[0]), .O_DATA_UART(dat[0]),
    .O_BUSY(busy[0]), .O_DONE(done[0]));

  debug_dump_serializer #(.N_WORDS(2), .WORD_W(32), .MSB_FIRST(1'b0)) dut_b (
    .CLK(CLK), .RESET(RESET), .I_START(I_START), .I_DATA(data_b),
    .I_TX_FULL(I_TX_FULL), .O_WR_UART(wr[1]), .O_DATA_UART(dat[1]),
    .O_BUSY(busy[1]), .O_DONE(done[1]));

  debug_dump_serializer #(.N_WORDS(1), .WORD_W(12), .HEADER_EN(1'b0),
    .CHECKSUM_EN(1'b0)) dut_c (
    .CLK(CLK), .RESET(RESET), .I_START(I_START), .I_DATA(data_c),
    .I_TX_FULL(I_TX_FULL), .O_WR_UART(wr[2]), .O_DATA_UART(dat[2]),
    .O_BUSY(busy[2]), .O_DONE(done[2]));

  debug_dump_serializer #(.N_WORDS(3), .WORD_W(20), .MSB_FIRST(1'b0),
    .SYNC_BYTE(8'h3C)) dut_d (
    .CLK(CLK), .RESET(RESET), .I_START(I_START), .I_DATA(data_d),
    .I_TX_FULL(I_TX_FULL), .O_WR_UART(wr[3]), .O_DATA_UART(dat[3]),
    .O_BUSY(busy[3]), .O_DONE(done[3]));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always_comb begin
    mwr   = wr[msel];
    mdat  = dat[msel];
    mbusy = busy[msel];
    mdone = done[msel];
  end

  function automatic logic [63:0] word_of(int s, int k);
    case (s)
      0:       return {32'b0, data_a[k*32 +: 32]};
      1:       return {32'b0, data_b[k*32 +: 32]};
      2:       return {52'b0, data_c};
      default: return {44'b0, data_d[k*20 +: 20]};
    endcase
  endfunction

  // Frame = [sync] + bytes of each zero-extended word + [xor of payload].
  function automatic void model(int s);
    logic [7:0]  x;
    logic [7:0]  by;
    logic [63:0] w;
    int          bpw;
    int          idx;
    bpw = (cw[s] + 7) / 8;
    exp = {};
    x   = 8'h00;
    if (ch[s]) exp.push_back(cs[s]);
    for (int k = 0; k < cn[s]; k++) begin
      w = word_of(s, k);
      for (int j = 0; j < bpw; j++) begin
        idx = cm[s] ? (bpw - 1 - j) : j;
        by  = 8'(w >> (8 * idx));
        exp.push_back(by);
        x = x ^ by;
      end
    end
    if (cc[s]) exp.push_back(x);
  endfunction

  task automatic randomize_data();
    data_a = {$urandom, $urandom};
    data_b = {$urandom, $urandom};
    data_c = 12'($urandom);
    data_d = {28'($urandom), $urandom};
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    I_START = 1'b0;
    while ((busy[0] || busy[1] || busy[2] || busy[3]) && k < 100) begin
      @(negedge CLK);
      k++;
    end
    n_cmp++;
    if (k >= 100) begin
      n_bad++;
      $display("FAIL idle_timeout: still busy after %0d cycles, want idle", k);
    end
  endtask

  task automatic collect(input int s, input bit hold, input int nfr,
                         input int stall_at, input int stall_n,
                         input int restart_at, input bit scramble,
                         input int tail);
    int left;
    left = stall_n;
    got = {}; t_wr = {}; t_done = {}; stall_d = {};
    idle_n = 0; extra = 0; full_wr = 0;
    msel = s;
    @(posedge CLK); #1;
    I_START = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 300; i++) begin
      @(posedge CLK); #1;
      if (!hold) I_START = 1'b0;
      if (i == 0 && scramble) randomize_data();
      I_TX_FULL = 1'b0;
      if (left > 0 && got.size() == stall_at) begin
        I_TX_FULL = 1'b1;
        left--;
      end
      if (restart_at > 0 && got.size() == restart_at) I_START = 1'b1;
      @(negedge CLK);
      if (t_done.size() < nfr) begin
        if (mwr) begin
          got.push_back(mdat);
          t_wr.push_back(cyc);
        end
        if (I_TX_FULL && mbusy) begin
          stall_d.push_back(mdat);
          if (mwr) full_wr++;
        end
        if (!mbusy && t_wr.size() > 0) idle_n++;
        if (mdone) t_done.push_back(cyc);
      end else if (mwr) begin
        extra++;
      end
      if (t_done.size() == nfr && cyc - t_done[nfr-1] >= tail) break;
    end
    I_START   = 1'b0;
    I_TX_FULL = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    for (int s = 0; s < 4; s++) begin
      n_cmp += 4;
      if (wr[s] !== 1'b0) begin
        n_bad++; $display("FAIL reset_wr[%0d]: got %b want 0", s, wr[s]);
      end
      if (dat[s] !== 8'h00) begin
        n_bad++; $display("FAIL reset_data[%0d]: got %h want 00", s, dat[s]);
      end
      if (busy[s] !== 1'b0) begin
        n_bad++; $display("FAIL reset_busy[%0d]: got %b want 0", s, busy[s]);
      end
      if (done[s] !== 1'b0) begin
        n_bad++; $display("FAIL reset_done[%0d]: got %b want 0", s, done[s]);
      end
    end
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (busy[0] !== 1'b0) begin
      n_bad++; $display("FAIL post_reset_busy: got %b want 0", busy[0]);
    end
  endtask

  task automatic check_frame(input string nm, input int nfr);
    logic [7:0] g;
    n_cmp++;
    if (t_done.size() != nfr) begin
      n_bad++;
      $display("FAIL %s_done_timeout: got %0d frames want %0d", nm, t_done.size(), nfr);
    end
    n_cmp++;
    if (got.size() != exp.size()) begin
      n_bad++;
      $display("FAIL %s_len: got %0d want %0d", nm, got.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      g = (i < got.size()) ? got[i] : 8'hxx;
      n_cmp++;
      if (g !== exp[i]) begin
        n_bad++;
        $display("FAIL %s_byte[%0d]: got %h want %h", nm, i, g, exp[i]);
      end
    end
  endtask

  task automatic test_msb_first();
    wait_idle();
    data_a = {32'hAABBCCDD, 32'h11223344};
    exp = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44,
            8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h44};
    collect(0, 1'b0, 1, 0, 0, 0, 1'b0, 0);
    check_frame("msb", 1);
    n_cmp += 4;
    if (t_wr[0] != c0 + 1) begin
      n_bad++; $display("FAIL msb_first_latency: got cyc %0d want %0d", t_wr[0], c0 + 1);
    end
    if (t_wr[$] - t_wr[0] != 9) begin
      n_bad++; $display("FAIL msb_consecutive: got span %0d want 9", t_wr[$] - t_wr[0]);
    end
    if (t_done[0] != t_wr[$] + 1) begin
      n_bad++; $display("FAIL msb_done_time: got %0d want %0d", t_done[0], t_wr[$] + 1);
    end
    if (idle_n != 0) begin
      n_bad++; $display("FAIL msb_busy_gap: got %0d idle cycles want 0", idle_n);
    end
    @(negedge CLK);
    n_cmp++;
    if (mbusy !== 1'b0) begin
      n_bad++; $display("FAIL msb_busy_after_done: got %b want 0", mbusy);
    end
  endtask

  task automatic test_lsb_first();
    wait_idle();
    data_b = {32'hAABBCCDD, 32'h11223344};
    exp = '{8'hA5, 8'h44, 8'h33, 8'h22, 8'h11,
            8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44};
    collect(1, 1'b0, 1, 0, 0, 0, 1'b0, 0);
    check_frame("lsb", 1);
  endtask

  task automatic test_backpressure();
    wait_idle();
    data_a = {32'hAABBCCDD, 32'h11223344};
    exp = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44,
            8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h44};
    collect(0, 1'b0, 1, 2, 5, 0, 1'b0, 0);
    check_frame("bp", 1);
    n_cmp += 2;
    if (stall_d.size() != 5) begin
      n_bad++; $display("FAIL bp_stall_len: got %0d want 5", stall_d.size());
    end
    if (full_wr != 0) begin
      n_bad++; $display("FAIL bp_write_while_full: got %0d want 0", full_wr);
    end
    foreach (stall_d[i]) begin
      n_cmp++;
      if (stall_d[i] !== 8'h22) begin
        n_bad++; $display("FAIL bp_hold[%0d]: got %h want 22", i, stall_d[i]);
      end
    end
  endtask

  task automatic test_narrow_word();
    wait_idle();
    data_c = 12'hABC;
    exp = '{8'h0A, 8'hBC};
    collect(2, 1'b0, 1, 0, 0, 0, 1'b1, 0);
    check_frame("narrow", 1);
    n_cmp += 2;
    if (t_wr[0] != c0 + 1) begin
      n_bad++; $display("FAIL narrow_latency: got %0d want %0d", t_wr[0], c0 + 1);
    end
    if (t_done[0] != t_wr[$] + 1) begin
      n_bad++; $display("FAIL narrow_done_time: got %0d want %0d", t_done[0], t_wr[$] + 1);
    end
  endtask

  task automatic test_reset_midframe();
    int n;
    wait_idle();
    n = 0;
    msel = 0;
    data_a = {32'hAABBCCDD, 32'h11223344};
    @(posedge CLK); #1;
    I_START = 1'b1;
    for (int i = 0; i < 50 && n < 4; i++) begin
      @(posedge CLK); #1;
      I_START = 1'b0;
      @(negedge CLK);
      if (mwr) n++;
    end
    @(posedge CLK); #1;
    RESET = 1'b1;
    #1;
    n_cmp += 4;
    if (mwr !== 1'b0) begin
      n_bad++; $display("FAIL midreset_wr: got %b want 0", mwr);
    end
    if (mdat !== 8'h00) begin
      n_bad++; $display("FAIL midreset_data: got %h want 00", mdat);
    end
    if (mbusy !== 1'b0) begin
      n_bad++; $display("FAIL midreset_busy: got %b want 0", mbusy);
    end
    if (mdone !== 1'b0) begin
      n_bad++; $display("FAIL midreset_done: got %b want 0", mdone);
    end
    @(negedge CLK);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    model(0);
    collect(0, 1'b0, 1, 0, 0, 0, 1'b0, 0);
    check_frame("after_reset", 1);
  endtask

  task automatic test_start_ignored();
    wait_idle();
    randomize_data();
    model(0);
    collect(0, 1'b0, 1, 0, 0, 5, 1'b0, 15);
    check_frame("ignored", 1);
    n_cmp++;
    if (extra != 0) begin
      n_bad++; $display("FAIL ignored_extra_writes: got %0d want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] one[$];
    wait_idle();
    randomize_data();
    model(0);
    one = exp;
    exp = {one, one};
    collect(0, 1'b1, 2, 0, 0, 0, 1'b0, 0);
    check_frame("b2b", 2);
    n_cmp += 2;
    if (idle_n != 1) begin
      n_bad++; $display("FAIL b2b_idle_gap: got %0d want 1", idle_n);
    end
    if (t_wr.size() < 11 || t_wr[10] != t_done[0] + 2) begin
      n_bad++;
      $display("FAIL b2b_restart_time: got %0d want %0d",
               (t_wr.size() > 10) ? t_wr[10] : -1, t_done[0] + 2);
    end
  endtask

  task automatic test_random();
    int s;
    string nm;
    for (int it = 0; it < 8; it++) begin
      wait_idle();
      s = int'($urandom_range(0, 3));
      randomize_data();
      model(s);
      collect(s, 1'b0, 1, int'($urandom_range(0, exp.size() - 1)),
              int'($urandom_range(0, 4)), 0, 1'b1, 0);
      nm = $sformatf("rnd%0d_s%0d", it, s);
      check_frame(nm, 1);
      n_cmp += 2;
      if (t_done[0] != t_wr[$] + 1) begin
        n_bad++; $display("FAIL %s_done_time: got %0d want %0d", nm, t_done[0], t_wr[$] + 1);
      end
      if (full_wr != 0) begin
        n_bad++; $display("FAIL %s_write_while_full: got %0d want 0", nm, full_wr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_backpressure();
    test_narrow_word();
    test_reset_midframe();
    test_start_ignored();
    test_back_to_back();
    test_random();
    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
